dmem_responder: RTL and testbench

Data-memory responder for the MIPS core's data-memory port. It is a 128×32 word store addressed by the CPU's word address A[6:0]. It uses active-low CEN/WEN/OEN. Writes complete in one cycle; reads return data after a programmable latency and hold the CPU with a stall signal. It also keeps saturating read and write access counters for performance checks in the testbench.

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS core's data port: 2**ADDR_W x DATA_W word store.
// Writes complete in a single cycle; reads stall the CPU for RD_LAT cycles.
module dmem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              stall,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dmem_responder: RD_LAT=%0d outside legal range 1..4", RD_LAT);
    end
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("dmem_responder: DEPTH=%0d must equal 2**ADDR_W", DEPTH);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Preload for the WAIT countdown; one latency cycle is spent in IDLE accepting.
    localparam logic [1:0] CNT_INIT = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        cnt_r;
    logic [DATA_W-1:0] q_r;
    logic [15:0]       rd_cnt_r;
    logic [15:0]       wr_cnt_r;
    logic              rd_acc_s;
    logic              wr_acc_s;

    // Requests are only accepted in IDLE; anything presented in WAIT/DONE is dropped.
    always_comb begin
        rd_acc_s = (state_r == IDLE) && !CEN && WEN;
        wr_acc_s = (state_r == IDLE) && !CEN && !WEN;
    end

    // Storage array: deliberately has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[A] <= D;
        end
    end

    // Read sequencer: IDLE accepts, WAIT counts down, DONE presents q_r for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            cnt_r   <= 2'd0;
            q_r     <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (rd_acc_s) begin
                        if (RD_LAT == 1) begin
                            q_r     <= mem[A];
                            state_r <= DONE;
                        end else begin
                            addr_r  <= A;
                            cnt_r   <= CNT_INIT;
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd0) begin
                        q_r     <= mem[addr_r];
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r - 2'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating access counters for accepted reads and writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else begin
            if (rd_acc_s) begin
                rd_cnt_r <= sat_inc(rd_cnt_r);
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
            if (wr_acc_s) begin
                wr_cnt_r <= sat_inc(wr_cnt_r);
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
        end
    end

    // Stall must rise in the accept cycle itself, so it is decoded from live inputs.
    always_comb begin
        stall  = rd_acc_s || (state_r == WAIT);
        Q      = OEN ? {DATA_W{1'b0}} : q_r;
        rd_cnt = rd_cnt_r;
        wr_cnt = wr_cnt_r;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at RD_LAT 1, 2 and 4 with
// independent CEN/rst_n and shared A/D/WEN/OEN.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n1, rst_n2, rst_n4;
    logic        cen1, cen2, cen4;
    logic        wen, oen;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] q1, q2, q4;
    logic        stall1, stall2, stall4;
    logic [15:0] rd_cnt1, rd_cnt2, rd_cnt4;
    logic [15:0] wr_cnt1, wr_cnt2, wr_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n1), .CEN(cen1), .WEN(wen), .OEN(oen), .A(a), .D(d),
        .Q(q1), .stall(stall1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
    );
    dmem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n2), .CEN(cen2), .WEN(wen), .OEN(oen), .A(a), .D(d),
        .Q(q2), .stall(stall2), .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
    );
    dmem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .RD_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n4), .CEN(cen4), .WEN(wen), .OEN(oen), .A(a), .D(d),
        .Q(q4), .stall(stall4), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n1 = 1'b0; rst_n2 = 1'b0; rst_n4 = 1'b0;
        cen1 = 1'b1; cen2 = 1'b1; cen4 = 1'b1;
        wen = 1'b1; oen = 1'b0; a = 7'd0; d = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n1 = 1'b1; rst_n2 = 1'b1; rst_n4 = 1'b1;

        smp();
        chk("rst_q2", q2, 32'd0);
        chk("rst_stall2", {31'd0, stall2}, 32'd0);
        chk("rst_rdcnt2", {16'd0, rd_cnt2}, 32'd0);
        chk("rst_wrcnt2", {16'd0, wr_cnt2}, 32'd0);
        chk("rst_q1", q1, 32'd0);
        chk("rst_q4", q4, 32'd0);

        // RD_LAT=2: write A=5 then read it back
        next(); cen2 = 1'b0; wen = 1'b0; a = 7'd5; d = 32'hDEADBEEF;
        smp(); chk("l2_wr_stall", {31'd0, stall2}, 32'd0);
        next(); wen = 1'b1;
        smp(); chk("l2_rd_stall_t", {31'd0, stall2}, 32'd1);
        next();
        smp(); chk("l2_rd_stall_t1", {31'd0, stall2}, 32'd1);
        next();
        smp(); chk("l2_done_stall", {31'd0, stall2}, 32'd0);
        chk("l2_done_q", q2, 32'hDEADBEEF);
        next(); cen2 = 1'b1;
        smp(); chk("l2_rdcnt", {16'd0, rd_cnt2}, 32'd1);
        chk("l2_wrcnt", {16'd0, wr_cnt2}, 32'd1);
        chk("l2_q_hold", q2, 32'hDEADBEEF);

        // RD_LAT=1: back-to-back writes, reads, write during DONE
        next(); cen1 = 1'b0; wen = 1'b0; a = 7'd0; d = 32'd1;
        smp(); chk("l1_wr0_stall", {31'd0, stall1}, 32'd0);
        next(); a = 7'd1; d = 32'd2;
        smp(); chk("l1_wr1_stall", {31'd0, stall1}, 32'd0);
        next(); a = 7'd127; d = 32'd3;
        smp(); chk("l1_wr127_stall", {31'd0, stall1}, 32'd0);
        next(); wen = 1'b1;
        smp(); chk("l1_rd127_stall", {31'd0, stall1}, 32'd1);
        next();
        smp(); chk("l1_rd127_done_stall", {31'd0, stall1}, 32'd0);
        chk("l1_rd127_q", q1, 32'd3);
        next(); a = 7'd1;
        smp(); chk("l1_rd1_stall", {31'd0, stall1}, 32'd1);
        next(); wen = 1'b0; d = 32'h00000BAD;
        smp(); chk("l1_rd1_done_stall", {31'd0, stall1}, 32'd0);
        chk("l1_rd1_q", q1, 32'd2);
        next(); cen1 = 1'b1; wen = 1'b1;
        smp(); chk("l1_wrcnt_done_ign", {16'd0, wr_cnt1}, 32'd3);
        chk("l1_rdcnt", {16'd0, rd_cnt1}, 32'd2);
        next(); cen1 = 1'b0; a = 7'd1;
        smp(); chk("l1_rerd1_stall", {31'd0, stall1}, 32'd1);
        next();
        smp(); chk("l1_mem_done_ign", q1, 32'd2);

        // OEN gating on RD_LAT=1
        next(); wen = 1'b0; a = 7'd10; d = 32'h12345678;
        next(); wen = 1'b1;
        smp(); chk("l1_rd10_stall", {31'd0, stall1}, 32'd1);
        next();
        smp(); chk("l1_rd10_q", q1, 32'h12345678);
        next(); cen1 = 1'b1; oen = 1'b1;
        smp(); chk("l1_oen_hi_q", q1, 32'd0);
        next(); oen = 1'b0;
        smp(); chk("l1_oen_lo_q", q1, 32'h12345678);
        chk("l1_rdcnt_4", {16'd0, rd_cnt1}, 32'd4);

        // RD_LAT=4: reset aborts a read in its second WAIT cycle
        next(); cen4 = 1'b0; wen = 1'b0; a = 7'd20; d = 32'hCAFEF00D;
        next(); wen = 1'b1;
        smp(); chk("l4_rd_stall_t", {31'd0, stall4}, 32'd1);
        next();
        smp(); chk("l4_rd_stall_wait1", {31'd0, stall4}, 32'd1);
        next(); rst_n4 = 1'b0; cen4 = 1'b1;
        #1;
        chk("l4_abort_stall", {31'd0, stall4}, 32'd0);
        chk("l4_abort_q", q4, 32'd0);
        chk("l4_abort_rdcnt", {16'd0, rd_cnt4}, 32'd0);
        smp(); rst_n4 = 1'b1;
        next(); cen4 = 1'b0; wen = 1'b1; a = 7'd20;
        smp(); chk("l4_rerd_stall0", {31'd0, stall4}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            next();
            smp(); chk("l4_rerd_stallN", {31'd0, stall4}, 32'd1);
        end
        next();
        smp(); chk("l4_rerd_done_stall", {31'd0, stall4}, 32'd0);
        chk("l4_rerd_q", q4, 32'hCAFEF00D);
        chk("l4_rerd_rdcnt", {16'd0, rd_cnt4}, 32'd1);
        next(); cen4 = 1'b1;

        // Write counter saturation on RD_LAT=2
        rst_n2 = 1'b0;
        #1;
        rst_n2 = 1'b1;
        chk("l2_rst_wrcnt", {16'd0, wr_cnt2}, 32'd0);
        cen2 = 1'b0; wen = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            a = 7'(i);
            d = 32'(i);
            next();
        end
        cen2 = 1'b1;
        smp(); chk("l2_wrcnt_sat", {16'd0, wr_cnt2}, 32'h0000FFFF);
        next(); cen2 = 1'b0; a = 7'd3; d = 32'h33;
        next();
        next(); cen2 = 1'b1;
        smp(); chk("l2_wrcnt_sat_hold", {16'd0, wr_cnt2}, 32'h0000FFFF);

        // Write presented during DONE on RD_LAT=2 must be dropped
        next(); cen2 = 1'b0; wen = 1'b1; a = 7'd3;
        next();
        next(); wen = 1'b0; d = 32'h44;
        smp(); chk("l2_rd3_q", q2, 32'h33);
        chk("l2_rd3_done_stall", {31'd0, stall2}, 32'd0);
        next(); wen = 1'b1;
        next();
        next(); cen2 = 1'b1;
        smp(); chk("l2_mem_done_ign", q2, 32'h33);
        chk("l2_rdcnt_after", {16'd0, rd_cnt2}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
